regfile: RTL
============

Name: regfile

Overview:
- Architectural integer register file for the br32 core: 32 x 32-bit registers; x0 reads as zero.
- Serves the responder side of the register-file interface:
  - two read ports for ID (rs1, rs2);
  - one read port for EX (rs3);
  - one write port from WB.
- Also holds a busy scoreboard. ID marks a destination busy at issue; the WB write clears it. ID uses the busy outputs to stall on RAW hazards.

Parameters:
- NUM_REGS, 32, number of architectural registers; index width is $clog2(NUM_REGS).
- XLEN, 32, register data width.

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- rst  input  1  asynchronous active-high reset.
- rs1  input  5  ID read index 1.
- rs1_val  output  32  value of rs1.
- rs2  input  5  ID read index 2.
- rs2_val  output  32  value of rs2.
- rs3  input  5  EX read index 3.
- rs3_val  output  32  value of rs3.
- w_rd  input  1  WB write enable.
- rd  input  5  WB write index.
- rd_val  input  32  WB write data.
- sb_set  input  1  ID issue strobe: mark sb_rd busy.
- sb_rd  input  5  destination of the issuing instruction.
- rs1_busy  output  1  rs1 has a write in flight.
- rs2_busy  output  1  rs2 has a write in flight.
- rs3_busy  output  1  rs3 has a write in flight.

Behaviour:
- Clock and reset: one clock (clk). rst is asynchronous and active-high. While rst is high, all registers x1..x31 are cleared to 0 and all busy bits are cleared, independent of clk.
- Outputs during and after reset: all rsN_val = 0 and all rsN_busy = 0.
- Reset mid-operation: any pending sb_set or write in that cycle is discarded.
- Read ports:
  - Combinational, zero latency: rsN_val = regs[rsN].
  - Index 0 always returns 0.
  - Reads never stall.
- Write port:
  - On a rising edge with w_rd=1 and rd!=0, regs[rd] <= rd_val.
  - w_rd with rd=0 is a no-op; x0 is never stored.
- Scoreboard:
  - busy[NUM_REGS-1:1] is registered state; busy[0] is constant 0.
  - Edge with sb_set=1, sb_rd!=0: busy[sb_rd] <= 1.
  - Edge with w_rd=1, rd!=0: busy[rd] <= 0.
  - sb_set and w_rd to the same register in the same cycle: set wins, so busy stays 1. The new in-flight writer supersedes the retiring one.
  - sb_set and w_rd to different registers in the same cycle: both take effect.
  - sb_set to an already-busy register: remains busy. There is no counting; the pipeline guarantees at most one in-flight writer per register.
  - w_rd to a non-busy register is legal (e.g. an unscoreboarded writer); the register is written and busy stays 0.
  - A set becomes visible on rsN_busy the cycle after sb_set.
- rsN_busy is registered busy[rsN], qualified by the bypass rule below.
- All three read ports are independent. Any combination of equal indices is legal.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined (write-first forwarding):
  - If w_rd=1, rd!=0 and rd==rsN, then rsN_val = rd_val in the same cycle.
  - rsN_busy = busy[rsN] & ~(w_rd & rd==rsN & rd!=0).
  - Exception: if sb_set targets the same register in that cycle, rsN_busy still deasserts this cycle; the new set appears next cycle.
- Undefined (no forwarding):
  - rsN_val and rsN_busy reflect registered state only.
  - A write becomes readable, and its busy bit clears, one cycle after the write edge.
  - ID must tolerate one extra stall cycle.

Decomposition:
- Package br32_pkg holds:
  - word_t (logic [XLEN-1:0]);
  - reg_idx_t (logic [4:0]);
  - constants NUM_REGS, XLEN and REG_ZERO = 5'd0.
- One sub-module, regfile_scoreboard, is natural. It contains:
  - the busy vector;
  - the set/clear priority logic;
  - three busy lookups with optional bypass qualification.
- regfile contains the storage array, the read muxes and the forwarding, and instantiates regfile_scoreboard.

Test Plan:
- Reset: assert rst asynchronously mid-cycle after writing x5=0xDEADBEEF -> rs1=5 reads 0 immediately and rs1_busy=0; values stay 0 after rst falls.
- x0: w_rd=1, rd=0, rd_val=0xFFFFFFFF, then rs1=rs2=rs3=0 -> all read 0; sb_set with sb_rd=0 -> rs1_busy stays 0.
- Write/read: write x7=0x12345678, then next cycle rs1=7, rs2=7, rs3=7 -> all read 0x12345678.
- Same-cycle read of the written register (rs2=9 while writing x9=0xA5A5A5A5, old value 0x11):
  - with REGFILE_BYPASS_EN -> rs2_val=0xA5A5A5A5 that cycle;
  - without it -> rs2_val=0x11 that cycle, 0xA5A5A5A5 the next.
- Scoreboard lifecycle: sb_set with sb_rd=3 -> rs1_busy (rs1=3) is 0 that cycle, 1 the next, and stays 1 until w_rd with rd=3. Clear timing:
  - with bypass -> deasserts in the w_rd cycle;
  - without bypass -> deasserts the cycle after.
- Set/clear collision:
  - same register (sb_set sb_rd=4 with w_rd rd=4, x4 previously busy) -> busy[4] stays 1 next cycle;
  - different registers (sb_rd=4, rd=6) -> rs1_busy(4)=1 and rs2_busy(6)=0 next cycle.

Source files
------------

// File: rtl/br32_pkg.sv
// Shared types and constants for the br32 integer register file.
package br32_pkg;

  localparam int NUM_REGS = 32;
  localparam int XLEN     = 32;
  localparam int IDX_W    = $clog2(NUM_REGS);

  typedef logic [XLEN-1:0]  word_t;
  typedef logic [IDX_W-1:0] reg_idx_t;

  localparam reg_idx_t REG_ZERO = 5'd0;

endpackage

// File: rtl/regfile_if.sv
// Register-file bus between the core pipeline (master) and the register file (slave).
interface regfile_if;
  import br32_pkg::*;

  reg_idx_t rs1;
  reg_idx_t rs2;
  reg_idx_t rs3;
  word_t    rs1_val;
  word_t    rs2_val;
  word_t    rs3_val;
  logic     w_rd;
  reg_idx_t rd;
  word_t    rd_val;
  logic     sb_set;
  reg_idx_t sb_rd;
  logic     rs1_busy;
  logic     rs2_busy;
  logic     rs3_busy;

  modport master (
    output rs1, rs2, rs3, w_rd, rd, rd_val, sb_set, sb_rd,
    input  rs1_val, rs2_val, rs3_val, rs1_busy, rs2_busy, rs3_busy
  );

  modport slave (
    input  rs1, rs2, rs3, w_rd, rd, rd_val, sb_set, sb_rd,
    output rs1_val, rs2_val, rs3_val, rs1_busy, rs2_busy, rs3_busy
  );

endinterface

// File: rtl/regfile_scoreboard.sv
// Busy scoreboard: one in-flight-writer bit per register, set at issue, cleared at writeback.
// REGFILE_BYPASS_EN makes a same-cycle writeback hide the busy bit it is about to clear.
module regfile_scoreboard
  import br32_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     sb_set,
  input  reg_idx_t sb_rd,
  input  logic     w_rd,
  input  reg_idx_t rd,
  input  reg_idx_t rs1,
  input  reg_idx_t rs2,
  input  reg_idx_t rs3,
  output logic     rs1_busy,
  output logic     rs2_busy,
  output logic     rs3_busy
);

  logic [NUM_REGS-1:0] busy_r;
  logic [NUM_REGS-1:0] busy_nxt_s;

`ifdef REGFILE_BYPASS_EN
  function automatic logic wb_hit(input logic wr, input reg_idx_t wr_idx, input reg_idx_t idx);
    return wr && (wr_idx == idx) && (idx != REG_ZERO);
  endfunction
`endif

  // Next busy vector: clear first so that a same-register issue overrides the retiring write.
  always_comb begin
    busy_nxt_s = busy_r;
    if (w_rd && (rd != REG_ZERO)) begin
      busy_nxt_s[rd] = 1'b0;
    end else begin
      busy_nxt_s[REG_ZERO] = 1'b0;
    end
    if (sb_set && (sb_rd != REG_ZERO)) begin
      busy_nxt_s[sb_rd] = 1'b1;
    end else begin
      busy_nxt_s[REG_ZERO] = 1'b0;
    end
    busy_nxt_s[REG_ZERO] = 1'b0;
  end

  // Busy state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_r <= {NUM_REGS{1'b0}};
    end else begin
      busy_r <= busy_nxt_s;
    end
  end

  // Busy lookups for the three read ports.
  always_comb begin
`ifdef REGFILE_BYPASS_EN
    rs1_busy = busy_r[rs1] & ~wb_hit(w_rd, rd, rs1);
    rs2_busy = busy_r[rs2] & ~wb_hit(w_rd, rd, rs2);
    rs3_busy = busy_r[rs3] & ~wb_hit(w_rd, rd, rs3);
`else
    rs1_busy = busy_r[rs1];
    rs2_busy = busy_r[rs2];
    rs3_busy = busy_r[rs3];
`endif
  end

endmodule

// File: rtl/regfile.sv
// br32 architectural register file: 3 combinational read ports, 1 write port, busy scoreboard.
// Optional write-first forwarding is enabled by defining REGFILE_BYPASS_EN.
module regfile
  import br32_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  regfile_if.slave  bus
);

  word_t      regs_r [NUM_REGS];
  logic [2:0] fwd_s;

  function automatic word_t pick(input reg_idx_t idx, input word_t stored,
                                 input logic fwd, input word_t fwd_val);
    if (idx == REG_ZERO) begin
      return {XLEN{1'b0}};
    end else if (fwd) begin
      return fwd_val;
    end else begin
      return stored;
    end
  endfunction

`ifdef REGFILE_BYPASS_EN
  // Forward the writeback data to any port reading the register being written; muted in reset.
  always_comb begin
    fwd_s[0] = ~rst & bus.w_rd & (bus.rd == bus.rs1) & (bus.rd != REG_ZERO);
    fwd_s[1] = ~rst & bus.w_rd & (bus.rd == bus.rs2) & (bus.rd != REG_ZERO);
    fwd_s[2] = ~rst & bus.w_rd & (bus.rd == bus.rs3) & (bus.rd != REG_ZERO);
  end
`else
  // No forwarding: reads see registered state only.
  always_comb begin
    fwd_s = 3'b000;
  end
`endif

  // Storage array; x0 is never written.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_r[i] <= {XLEN{1'b0}};
      end
    end else if (bus.w_rd && (bus.rd != REG_ZERO)) begin
      regs_r[bus.rd] <= bus.rd_val;
    end else begin
      regs_r[REG_ZERO] <= {XLEN{1'b0}};
    end
  end

  // Read muxes.
  always_comb begin
    bus.rs1_val = pick(bus.rs1, regs_r[bus.rs1], fwd_s[0], bus.rd_val);
    bus.rs2_val = pick(bus.rs2, regs_r[bus.rs2], fwd_s[1], bus.rd_val);
    bus.rs3_val = pick(bus.rs3, regs_r[bus.rs3], fwd_s[2], bus.rd_val);
  end

  regfile_scoreboard u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .sb_set   (bus.sb_set),
    .sb_rd    (bus.sb_rd),
    .w_rd     (bus.w_rd),
    .rd       (bus.rd),
    .rs1      (bus.rs1),
    .rs2      (bus.rs2),
    .rs3      (bus.rs3),
    .rs1_busy (bus.rs1_busy),
    .rs2_busy (bus.rs2_busy),
    .rs3_busy (bus.rs3_busy)
  );

endmodule
